// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; tick marks a bit sample point and the counter then reloads one bit period.
module uart_baud_cnt #(
  parameter int unsigned Width  = 6,
  parameter int unsigned Reload = 51
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  localparam logic [Width-1:0] ReloadVal = Width'(Reload);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = tick ? ReloadVal : cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: two-flop synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 6000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV     = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF    = calc_half(DIV);
  localparam int unsigned CntW    = $clog2(DIV);
  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0]    HalfLoad = CntW'(HALF - 1);
  localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_BITS - 1);

  logic s1_q, s2_q;

  uart_state_e state_q, state_d;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bitcnt_q, bitcnt_d;
  logic                 pend_q, pend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic cnt_load, cnt_en, tick;

  uart_baud_cnt #(
    .Width (CntW),
    .Reload(DIV - 1)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(HalfLoad),
    .en      (cnt_en),
    .tick    (tick)
  );

  // Frame recovery; pend_d flags a good stop bit for delivery on the following cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    pend_d      = 1'b0;
    frame_err_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!s2_q) begin
          state_d  = StStart;
          cnt_load = 1'b1;
        end
      end
      StStart: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (s2_q) begin
            state_d = StIdle;
          end else begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
      end
      StData: begin
        cnt_en = 1'b1;
        if (tick) begin
          shift_d  = {s2_q, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BitCntW'(1);
          if (bitcnt_q == LastBit) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (s2_q) begin
            pend_d  = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Stay here until the line is released so a held-low line is not a new start bit.
        if (s2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a consumer handshake in the delivery cycle frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (pend_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= StIdle;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= rx;
      s2_q        <= s1_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      pend_q      <= pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

  err_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(frame_err_q && overrun_q));

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: serial waveforms built from byte lists, checked each cycle against
// an event schedule (deliveries, error pulses, busy windows) derived from frame start times.
module tb_uart_rx_frontend;

  localparam int unsigned CLK_HZ = 6000000;
  localparam int unsigned BAUD   = 115200;
  localparam int DIV      = 52;                   // 6e6 / 115200 = 52.08
  localparam int HALF     = 26;
  localparam int LAT      = 3 + HALF + 9 * DIV;   // start edge to valid
  localparam int STOP_OFS = 2 + HALF + 9 * DIV;   // start edge to stop-bit sample

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  typedef struct {
    int lo;
    int hi;
  } span_t;

  int total = 0;
  int bad = 0;
  int edge_idx = 0;

  bit           line_q[$];
  bit           rdy_in, rst_in;
  byte unsigned deliv_at[int];
  bit           ferr_at[int];
  span_t        busy_q[$];

  bit         m_valid, m_ferr, m_ovr, m_busy;
  logic [7:0] m_data;

  // Expected outputs after edge e, given the ready/reset values presented before it.
  task automatic model_edge(input int e, input bit r, input bit rs);
    int kill[$];
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (!rs) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_busy  = 1'b0;
      foreach (deliv_at[k]) if (k >= e) kill.push_back(k);
      foreach (kill[i]) deliv_at.delete(kill[i]);
      kill.delete();
      foreach (ferr_at[k]) if (k >= e) kill.push_back(k);
      foreach (kill[i]) ferr_at.delete(kill[i]);
      foreach (busy_q[i]) if (busy_q[i].hi >= e) busy_q[i].hi = e - 1;
      return;
    end
    if (deliv_at.exists(e)) begin
      if (!m_valid || r) begin
        m_data  = deliv_at[e];
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (ferr_at.exists(e)) m_ferr = 1'b1;
    m_busy = 1'b0;
    foreach (busy_q[i]) if (e >= busy_q[i].lo && e <= busy_q[i].hi) m_busy = 1'b1;
  endtask

  // Drive one cycle at the negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle();
    rx    = (line_q.size() != 0) ? line_q.pop_front() : 1'b1;
    ready = rdy_in;
    rst   = rst_in;
    @(posedge clk);
    model_edge(edge_idx, rdy_in, rst_in);
    edge_idx++;
    @(negedge clk);
  endtask

  task automatic add_idle(input int n);
    repeat (n) line_q.push_back(1'b1);
  endtask

  task automatic add_frame(input byte unsigned b, input bit stop_hi, input int extra,
                           output int k0);
    span_t s;
    k0 = edge_idx + line_q.size();
    repeat (DIV) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (DIV) line_q.push_back(b[i]);
    repeat (DIV) line_q.push_back(stop_hi);
    s.lo = k0 + 2;
    if (stop_hi) begin
      deliv_at[k0 + LAT] = b;
      s.hi = k0 + STOP_OFS - 1;
    end else begin
      repeat (extra * DIV) line_q.push_back(1'b0);
      ferr_at[k0 + STOP_OFS] = 1'b1;
      s.hi = k0 + (10 + extra) * DIV + 1;
      add_idle(2);
    end
    busy_q.push_back(s);
  endtask

  task automatic add_glitch(input int n, output int k0);
    span_t s;
    k0 = edge_idx + line_q.size();
    repeat (n) line_q.push_back(1'b0);
    s.lo = k0 + 2;
    s.hi = k0 + 1 + HALF;
    busy_q.push_back(s);
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) rst_in = 1'b1;
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL reset valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL reset data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL reset frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL reset overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL reset busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
    end
  endtask

  task automatic test_single();
    int k0, rise, nvalid;
    rdy_in = 1'b1;
    add_idle(5);
    add_frame(8'h55, 1'b1, 0, k0);
    add_idle(40);
    rise = -1;
    nvalid = 0;
    while (line_q.size() != 0) begin
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL single valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL single data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL single frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL single overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL single busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
      if (valid === 1'b1) begin
        nvalid++;
        if (rise < 0) rise = edge_idx - 1;
      end
    end
    total++; if (rise - k0 != LAT) begin bad++; $display("FAIL single latency got=%0d want=%0d", rise - k0, LAT); end
    total++; if (nvalid != 1) begin bad++; $display("FAIL single valid_cycles got=%0d want=1", nvalid); end
  endtask

  task automatic test_overrun();
    int ka, kb, novr;
    rdy_in = 1'b0;
    add_frame(8'hA3, 1'b1, 0, ka);
    add_frame(8'h0F, 1'b1, 0, kb);
    add_idle(20);
    novr = 0;
    while (line_q.size() != 0) begin
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL overrun valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL overrun data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL overrun frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL overrun overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL overrun busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
      if (overrun === 1'b1) novr++;
    end
    total++; if (novr != 1) begin bad++; $display("FAIL overrun pulses got=%0d want=1", novr); end
    total++; if (valid !== 1'b1 || data !== 8'hA3) begin bad++; $display("FAIL overrun hold got=%b/%h want=1/a3", valid, data); end
    rdy_in = 1'b1;
    cycle();
    rdy_in = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL overrun accept valid got=%b want=0", valid); end
    total++; if (data !== 8'hA3) begin bad++; $display("FAIL overrun accept data got=%h want=a3", data); end
  endtask

  task automatic test_break();
    int ka, kb, nferr, nvalid;
    rdy_in = 1'b1;
    add_frame(8'h3C, 1'b0, 2, ka);
    add_idle(20);
    add_frame(8'h7E, 1'b1, 0, kb);
    add_idle(40);
    nferr = 0;
    nvalid = 0;
    while (line_q.size() != 0) begin
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL break valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL break data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL break frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL break overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL break busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
      if (frame_err === 1'b1) nferr++;
      if (valid === 1'b1) nvalid++;
    end
    total++; if (nferr != 1) begin bad++; $display("FAIL break frame_err_pulses got=%0d want=1", nferr); end
    total++; if (nvalid != 1) begin bad++; $display("FAIL break deliveries got=%0d want=1", nvalid); end
  endtask

  task automatic test_glitch();
    int kg, nev;
    rdy_in = 1'b1;
    add_idle(3);
    add_glitch(10, kg);
    add_idle(60);
    nev = 0;
    while (line_q.size() != 0) begin
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL glitch valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL glitch frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL glitch overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL glitch busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
      if (valid === 1'b1 || frame_err === 1'b1 || overrun === 1'b1) nev++;
    end
    total++; if (nev != 0) begin bad++; $display("FAIL glitch events got=%0d want=0", nev); end
  endtask

  task automatic test_reset_mid();
    int ka, kb, n81;
    rdy_in = 1'b1;
    add_frame(8'hFF, 1'b1, 0, ka);
    n81 = 0;
    for (int i = 0; line_q.size() != 0 || i < 700; i++) begin
      rst_in = (i != 200);
      if (i == 260) begin
        add_idle(10);
        add_frame(8'h81, 1'b1, 0, kb);
        add_idle(40);
      end
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL reset_mid valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL reset_mid data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL reset_mid frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL reset_mid overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL reset_mid busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
      if (valid === 1'b1 && data === 8'h81) n81++;
    end
    rst_in = 1'b1;
    total++; if (n81 != 1) begin bad++; $display("FAIL reset_mid rx81 got=%0d want=1", n81); end
  endtask

  task automatic test_simul();
    int ka, kb, d2, novr;
    rdy_in = 1'b0;
    add_frame(8'h11, 1'b1, 0, ka);
    add_idle(30);
    add_frame(8'h22, 1'b1, 0, kb);
    add_idle(10);
    d2 = kb + LAT;
    novr = 0;
    while (line_q.size() != 0) begin
      rdy_in = (edge_idx == d2);
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL simul valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL simul data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL simul overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      if (overrun === 1'b1) novr++;
    end
    total++; if (novr != 0) begin bad++; $display("FAIL simul overrun_pulses got=%0d want=0", novr); end
    total++; if (valid !== 1'b1 || data !== 8'h22) begin bad++; $display("FAIL simul final got=%b/%h want=1/22", valid, data); end
    rdy_in = 1'b1;
    cycle();
    rdy_in = 1'b0;
  endtask

  task automatic test_random();
    int k;
    byte unsigned b;
    bit good;
    for (int f = 0; f < 6; f++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      add_frame(b, good, int'($urandom_range(0, 2)), k);
      add_idle(int'($urandom_range(0, 40)));
    end
    add_idle(40);
    while (line_q.size() != 0) begin
      rdy_in = ($urandom_range(0, 3) == 0);
      cycle();
      total++; if (valid !== m_valid) begin bad++; $display("FAIL random valid e=%0d got=%b want=%b", edge_idx - 1, valid, m_valid); end
      total++; if (data !== m_data) begin bad++; $display("FAIL random data e=%0d got=%h want=%h", edge_idx - 1, data, m_data); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL random frame_err e=%0d got=%b want=%b", edge_idx - 1, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL random overrun e=%0d got=%b want=%b", edge_idx - 1, overrun, m_ovr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL random busy e=%0d got=%b want=%b", edge_idx - 1, busy, m_busy); end
    end
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    ready = 1'b0;
    rst_in = 1'b0;
    rdy_in = 1'b0;
    m_valid = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    m_busy = 1'b0;
    m_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid();
    test_simul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached at edge %0d", edge_idx);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Receive stage between the board-level `uart_rx` pin and the `system` core.
- Synchronises the asynchronous serial line and recovers 8N1 frames by mid-bit sampling.
- Delivers each byte through a one-entry valid/ready holding register.
- Flags framing errors and overruns so the core can count or report them.

Parameters:
- CLK_HZ, 6000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- DIV, round(CLK_HZ/BAUD) = 52, clocks per bit (derived, not overridden).
- HALF, DIV/2 = 26, clocks from start-bit detection to start-bit centre (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- rx  in  1  asynchronous serial input; idles high.
- data  out  8  received byte; valid only while `valid`=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts `data` on a cycle with valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a new byte was dropped because the holding register was still full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0 at a clock edge): sync flops=1, state=IDLE, data=0x00, valid=0, frame_err=0, overrun=0, busy=0, counters=0. A reset mid-frame abandons the frame with no pulse.
- Synchroniser: two flops, rx -> s1 -> s2. The FSM uses s2 only.
- Baud counter:
  - Down-counter, width clog2(DIV).
  - A sample point is a cycle where counter==0; the counter then reloads DIV-1.
- FSM:
  - IDLE: s2==0 -> START, counter=HALF-1.
  - START: at the sample point, s2==1 -> IDLE (glitch rejected, no pulse); s2==0 -> DATA, bitcnt=0.
  - DATA: at each sample point, shift={s2,shift[7:1]} (LSB first) and bitcnt++. After the 8th sample -> STOP.
  - STOP, sample point, s2==1: deliver the byte, -> IDLE.
  - STOP, sample point, s2==0: pulse frame_err, discard the byte, -> BREAK.
  - BREAK: wait for s2==1, then -> IDLE. This prevents a held-low line from being re-read as a new start bit.
- Delivery, in the cycle after the STOP sample:
  - If valid==0, or valid && ready in that same cycle: data=shift, valid=1.
  - If valid && !ready: keep the old data, pulse overrun, drop the new byte.
- Handshake: valid && ready with no simultaneous delivery -> valid=0 next cycle; data is held. `ready` while valid=0 is ignored.
- Latency: `valid` rises exactly 3 + HALF + 9*DIV cycles after the first clock edge that samples rx low. This is 497 cycles at the default parameters.
- Back-to-back frames: a new start bit is detected the cycle after returning to IDLE. No extra idle time is required.
- frame_err and overrun are never asserted in the same cycle as each other.

Decomposition:
- Shared package `uart_pkg`:
  - State enum IDLE/START/DATA/STOP/BREAK.
  - Function computing DIV/HALF from CLK_HZ and BAUD.
  - Constant DATA_BITS=8.
- One natural sub-module, `uart_baud_cnt`:
  - Loadable down-counter with a sample-point strobe.
  - Reusable by the transmit path.

Test Plan:
- Send 0x55 at DIV=52, ready=1 -> valid high one cycle at 497 cycles after the start edge; data=0x55; no error pulses.
- Send 0xA3 then 0x0F back-to-back, ready=0 until both frames finish -> data=0xA3 held, overrun pulses once, valid stays 1. Then ready=1 for one cycle -> valid=0.
- Send 0x3C with the stop bit driven low, then release the line high after 2 bit times -> frame_err pulses once, valid stays 0. FSM passes through BREAK and returns to IDLE; a following 0x7E is received correctly.
- Drive rx low for 10 cycles, then high -> FSM returns to IDLE at the start sample; no valid, frame_err or overrun.
- Assert rst=0 for one cycle mid-DATA of a 0xFF frame -> all outputs reset next cycle. The partial frame yields no byte; the next full frame 0x81 is received.
- Hold valid=1 with 0x11 and assert ready in the same cycle a new 0x22 completes -> no overrun; data=0x22, valid stays 1.
